// File: rtl/i2s_sample_fifo.sv
// Stereo PCM sample FIFO feeding the I2S DAC serializer: buffers {left,right}
// pairs and advances the held output pair once per frame on the lrck rising edge.
module i2s_sample_fifo #(
    parameter int unsigned  DEPTH_LOG2       = 4,
    parameter bit           MUTE_ON_UNDERRUN = 1'b0,
    parameter logic [15:0]  RESET_LEVEL      = 16'h8000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [15:0]           in_left,
    input  logic [15:0]           in_right,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  lrck,
    output logic [15:0]           left,
    output logic [15:0]           right,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  underrun,
    input  logic                  underrun_clr
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);

    // Handshake: a pair transfers on any posedge where in_valid & in_ready;
    // in_ready is a registered ~full and never depends on in_valid or lrck.
    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  full;
    logic                  lrck_q;
    logic                  push;
    logic                  pop_stb;
    logic                  pop;
    logic                  empty_pop;
    logic [DEPTH_LOG2:0]   level_next;

    assign in_ready  = ~full;
    assign push      = in_valid & ~full;
    assign pop_stb   = lrck & ~lrck_q;
    assign pop       = pop_stb & (level != '0);
    assign empty_pop = pop_stb & (level == '0);

    always_comb begin
        level_next = level;
        if (push && !pop) begin
            level_next = level + 1'b1;
        end else if (!push && pop) begin
            level_next = level - 1'b1;
        end
    end

    // Storage is deliberately left unreset; level/pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_left, in_right};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            full     <= 1'b0;
            underrun <= 1'b0;
            lrck_q   <= 1'b0;
            left     <= RESET_LEVEL;
            right    <= RESET_LEVEL;
        end else begin
            lrck_q <= lrck;
            level  <= level_next;
            full   <= (level_next == FULL_LEVEL);
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                {left, right} <= mem[rd_ptr];
                rd_ptr        <= rd_ptr + 1'b1;
            end else if (empty_pop && MUTE_ON_UNDERRUN) begin
                left  <= 16'h0000;
                right <= 16'h0000;
            end
            // A new underrun wins over a clear requested in the same cycle.
            if (empty_pop) begin
                underrun <= 1'b1;
            end else if (underrun_clr) begin
                underrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_sample_fifo.sv
// Bench for i2s_sample_fifo: directed scenarios plus randomized traffic,
// checked against a queue-based model of the frame-paced FIFO.
module tb_i2s_sample_fifo;

    localparam int DL    = 2;
    localparam int DEPTH = 1 << DL;
    localparam bit MUTE  = 1'b0;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [15:0]   in_left = '0;
    logic [15:0]   in_right = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          lrck = 1'b0;
    logic [15:0]   left;
    logic [15:0]   right;
    logic [DL:0]   level;
    logic          underrun;
    logic          underrun_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] exp_q[$];
    logic [15:0] m_left;
    logic [15:0] m_right;
    logic        m_underrun;
    logic        m_lrck_q;

    i2s_sample_fifo #(
        .DEPTH_LOG2(DL),
        .MUTE_ON_UNDERRUN(MUTE),
        .RESET_LEVEL(16'h8000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_left(in_left),
        .in_right(in_right),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .lrck(lrck),
        .left(left),
        .right(right),
        .level(level),
        .underrun(underrun),
        .underrun_clr(underrun_clr)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        exp_q.delete();
        m_left     = 16'h8000;
        m_right    = 16'h8000;
        m_underrun = 1'b0;
        m_lrck_q   = 1'b0;
    endtask

    // Advance model by one clock using the inputs currently driven, then step the DUT.
    task automatic tick(output bit acc);
        bit rise;
        acc  = in_valid && (exp_q.size() < DEPTH);
        rise = lrck && !m_lrck_q;
        if (rise && exp_q.size() != 0) begin
            {m_left, m_right} = exp_q.pop_front();
        end
        if (rise && exp_q.size() == 0 && !acc) begin
            // empty-queue rise is modelled in step()
        end
        m_lrck_q = lrck;
        @(posedge clk);
        #1;
    endtask

    // Full model step: pop/underrun decided before the same-cycle push lands.
    task automatic step(output bit acc);
        bit rise;
        bit was_empty;
        acc       = in_valid && (exp_q.size() < DEPTH);
        rise      = lrck && !m_lrck_q;
        was_empty = (exp_q.size() == 0);
        if (rise && !was_empty) begin
            {m_left, m_right} = exp_q.pop_front();
        end
        if (rise && was_empty) begin
            m_underrun = 1'b1;
            if (MUTE) begin
                m_left  = 16'h0000;
                m_right = 16'h0000;
            end
        end else if (underrun_clr) begin
            m_underrun = 1'b0;
        end
        if (acc) exp_q.push_back({in_left, in_right});
        m_lrck_q = lrck;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid     = 1'b0;
        lrck         = 1'b0;
        underrun_clr = 1'b0;
        reset        = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bit acc;
        do_reset();
        checks++;
        if ({left, right, level, underrun, in_ready} !== {16'h8000, 16'h8000, 3'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state got %h/%h lvl %0d ur %b rdy %b exp 8000/8000 lvl 0 ur 0 rdy 1",
                     left, right, level, underrun, in_ready);
        end
        step(acc);
    endtask

    task automatic test_push_three();
        bit acc;
        logic [31:0] pairs [3];
        pairs[0] = 32'h1111AAAA;
        pairs[1] = 32'h2222BBBB;
        pairs[2] = 32'h3333CCCC;
        for (int i = 0; i < 3; i++) begin
            {in_left, in_right} = pairs[i];
            in_valid = 1'b1;
            step(acc);
        end
        in_valid = 1'b0;
        checks++;
        if ({level, in_ready, left, right} !== {3'd3, 1'b1, 16'h8000, 16'h8000}) begin
            errors++;
            $display("FAIL push_three got lvl %0d rdy %b %h/%h exp lvl 3 rdy 1 8000/8000",
                     level, in_ready, left, right);
        end
    endtask

    // One frame: 32 clk with lrck high, 32 low, every cycle compared to the model.
    task automatic run_frame(input string name);
        bit acc;
        for (int c = 0; c < 64; c++) begin
            lrck = (c < 32);
            step(acc);
            checks++;
            if ({left, right, level, underrun, in_ready} !==
                {m_left, m_right, 3'(exp_q.size()), m_underrun, 1'(exp_q.size() < DEPTH)}) begin
                errors++;
                $display("FAIL %s cyc %0d got %h/%h lvl %0d ur %b rdy %b exp %h/%h lvl %0d ur %b",
                         name, c, left, right, level, underrun, in_ready,
                         m_left, m_right, exp_q.size(), m_underrun);
            end
        end
    endtask

    task automatic test_frames();
        logic [31:0] want [3];
        want[0] = 32'h1111AAAA;
        want[1] = 32'h2222BBBB;
        want[2] = 32'h3333CCCC;
        for (int f = 0; f < 3; f++) begin
            run_frame("frames");
            checks++;
            if ({left, right, level, underrun} !== {want[f], 3'(2 - f), 1'b0}) begin
                errors++;
                $display("FAIL frame_pair %0d got %h/%h lvl %0d ur %b exp %h lvl %0d ur 0",
                         f, left, right, level, underrun, want[f], 2 - f);
            end
        end
    endtask

    task automatic test_underrun();
        bit acc;
        run_frame("underrun_frame");
        checks++;
        if ({underrun, left, right} !== {1'b1, MUTE ? 32'h0 : 32'h3333CCCC}) begin
            errors++;
            $display("FAIL underrun_set got ur %b %h/%h exp ur 1 %h",
                     underrun, left, right, MUTE ? 32'h0 : 32'h3333CCCC);
        end
        underrun_clr = 1'b1;
        step(acc);
        underrun_clr = 1'b0;
        checks++;
        if (underrun !== 1'b0) begin
            errors++;
            $display("FAIL underrun_clr got %b exp 0", underrun);
        end
    endtask

    task automatic test_full();
        bit acc;
        int accepted = 0;
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_left  = 16'($urandom);
            in_right = 16'($urandom);
            step(acc);
            if (acc) accepted++;
        end
        checks++;
        if ({level, in_ready} !== {3'd4, 1'b0} || accepted != 4) begin
            errors++;
            $display("FAIL full_fill got lvl %0d rdy %b exp lvl 4 rdy 0 (model accepted %0d)",
                     level, in_ready, accepted);
        end
        lrck = 1'b1;
        step(acc);
        if (acc) accepted++;
        checks++;
        if ({level, in_ready} !== {3'd3, 1'b1}) begin
            errors++;
            $display("FAIL full_pop got lvl %0d rdy %b exp lvl 3 rdy 1", level, in_ready);
        end
        lrck = 1'b0;
        in_left = 16'h5555;
        in_right = 16'hDDDD;
        step(acc);
        if (acc) accepted++;
        in_valid = 1'b0;
        checks++;
        if ({level, in_ready} !== {3'd4, 1'b0} || accepted != 5) begin
            errors++;
            $display("FAIL full_refill got lvl %0d rdy %b exp lvl 4 rdy 0", level, in_ready);
        end
        // Drain and confirm the fifth pair comes out last.
        for (int f = 0; f < 4; f++) begin
            lrck = 1'b1;
            step(acc);
            lrck = 1'b0;
            step(acc);
        end
        checks++;
        if ({left, right, level} !== {16'h5555, 16'hDDDD, 3'd0}) begin
            errors++;
            $display("FAIL full_drain got %h/%h lvl %0d exp 5555/dddd lvl 0", left, right, level);
        end
    endtask

    task automatic test_push_on_rise();
        bit acc;
        do_reset();
        step(acc);
        lrck     = 1'b1;
        in_valid = 1'b1;
        in_left  = 16'h7E57;
        in_right = 16'h0BAD;
        step(acc);
        in_valid = 1'b0;
        checks++;
        if ({underrun, level, left, right} !== {1'b1, 3'd1, 16'h8000, 16'h8000}) begin
            errors++;
            $display("FAIL rise_push got ur %b lvl %0d %h/%h exp ur 1 lvl 1 8000/8000",
                     underrun, level, left, right);
        end
        lrck = 1'b0;
        step(acc);
        lrck = 1'b1;
        step(acc);
        checks++;
        if ({left, right, level} !== {16'h7E57, 16'h0BAD, 3'd0}) begin
            errors++;
            $display("FAIL rise_push_out got %h/%h lvl %0d exp 7e57/0bad lvl 0", left, right, level);
        end
    endtask

    task automatic test_reset_mid();
        bit acc;
        do_reset();
        in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_left  = 16'(i * 16'h1111);
            in_right = 16'(16'h9999 + i * 16'h1111);
            step(acc);
        end
        in_valid = 1'b0;
        for (int f = 0; f < 2; f++) begin
            lrck = 1'b1;
            step(acc);
            lrck = 1'b0;
            step(acc);
        end
        checks++;
        if ({left, level} !== {16'h2222, 3'd2}) begin
            errors++;
            $display("FAIL mid_pre got %h lvl %0d exp 2222 lvl 2", left, level);
        end
        reset = 1'b1;
        model_reset();
        #2;
        checks++;
        if ({left, right, level, in_ready, underrun} !== {16'h8000, 16'h8000, 3'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset got %h/%h lvl %0d rdy %b ur %b exp 8000/8000 lvl 0 rdy 1 ur 0",
                     left, right, level, in_ready, underrun);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        lrck = 1'b1;
        step(acc);
        checks++;
        if ({underrun, level, left} !== {1'b1, 3'd0, 16'h8000}) begin
            errors++;
            $display("FAIL mid_after got ur %b lvl %0d %h exp ur 1 lvl 0 8000", underrun, level, left);
        end
        lrck = 1'b0;
        step(acc);
    endtask

    task automatic test_random();
        bit acc;
        int half = 3;
        int cnt  = 0;
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            if (cnt >= half) begin
                lrck = ~lrck;
                cnt  = 0;
                half = $urandom_range(1, 6);
            end
            cnt++;
            in_valid     = ($urandom_range(0, 2) != 0);
            in_left      = 16'($urandom);
            in_right     = 16'($urandom);
            underrun_clr = ($urandom_range(0, 15) == 0);
            step(acc);
            checks++;
            if ({left, right, level, underrun, in_ready} !==
                {m_left, m_right, 3'(exp_q.size()), m_underrun, 1'(exp_q.size() < DEPTH)}) begin
                errors++;
                $display("FAIL random cyc %0d got %h/%h lvl %0d ur %b rdy %b exp %h/%h lvl %0d ur %b",
                         c, left, right, level, underrun, in_ready,
                         m_left, m_right, exp_q.size(), m_underrun);
            end
        end
        in_valid     = 1'b0;
        underrun_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_push_three();
        test_frames();
        test_underrun();
        test_full();
        test_push_on_rise();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
